// File: rtl/md_pkg.sv
// Shared constants and helpers for the HI/LO multiply/divide scheduler.
package md_pkg;

   localparam logic [2:0]  MD_NONE  = 3'd0;
   localparam logic [2:0]  MD_MULT  = 3'd1;
   localparam logic [2:0]  MD_MULTU = 3'd2;
   localparam logic [2:0]  MD_DIV   = 3'd3;
   localparam logic [2:0]  MD_DIVU  = 3'd4;
   localparam logic [31:0] DIVZ_LO  = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } md_state_e;

   // Codes 5..7 are not unit operations and behave like MD_NONE.
   function automatic logic is_md_op(input logic [2:0] op);
      return (op != MD_NONE) && (op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU});
   endfunction

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic is_signed_op(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/md_lat_counter.sv
// Loadable down-counter that times the fixed latency of the multiply/divide unit.
module md_lat_counter #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q;

   // Count register: load wins over decrement, never wraps below zero.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= {CNT_W{1'b0}};
      end else if (load) begin
         cnt_q <= load_val;
      end else if (dec && (cnt_q != {CNT_W{1'b0}})) begin
         cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_q <= cnt_q;
      end
   end

   assign zero = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/md_sched.sv
// Issues mult/div operations to the shared HI/LO unit, times them, writes results
// back and stalls the pipeline while a dependent instruction waits for the unit.
module md_sched
   import md_pkg::*;
#(
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 33,
   parameter int CNT_W   = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  Eop,
   input  logic [31:0] Ea,
   input  logic [31:0] Eb,
   input  logic        Erd_hilo,
   input  logic        exc_flush,
   input  logic [31:0] md_hi,
   input  logic [31:0] md_lo,
   output logic        md_start,
   output logic        md_isdiv,
   output logic        md_signed,
   output logic [31:0] md_a,
   output logic [31:0] md_b,
   output logic        stall,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out,
   output logic        w_hi,
   output logic        w_lo
);

   md_state_e        state_q, state_d;
   logic             accept_s, divz_s, capture_s;
   logic             cnt_load_s, cnt_dec_s, cnt_zero_s;
   logic [CNT_W-1:0] load_val_s;
   logic             start_q, isdiv_q, signed_q, done_q;
   logic [31:0]      a_q, b_q, hi_q, lo_q;

   assign load_val_s = is_div_op(Eop) ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);

   md_lat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load_s),
      .load_val (load_val_s),
      .dec      (cnt_dec_s),
      .zero     (cnt_zero_s)
   );

   // Next-state logic; a zero divisor skips the unit entirely.
   always_comb begin
      state_d    = state_q;
      accept_s   = 1'b0;
      divz_s     = 1'b0;
      capture_s  = 1'b0;
      cnt_load_s = 1'b0;
      cnt_dec_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (is_md_op(Eop) && !exc_flush) begin
               accept_s = 1'b1;
               if (is_div_op(Eop) && (Eb == 32'd0)) begin
                  divz_s  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  cnt_load_s = 1'b1;
                  state_d    = ST_BUSY;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (exc_flush) begin
               state_d = ST_IDLE;
            end else if (cnt_zero_s) begin
               capture_s = 1'b1;
               state_d   = ST_DONE;
            end else begin
               cnt_dec_s = 1'b1;
               state_d   = ST_BUSY;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, operand latches and result registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         start_q  <= 1'b0;
         isdiv_q  <= 1'b0;
         signed_q <= 1'b0;
         done_q   <= 1'b0;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
      end else begin
         state_q <= state_d;
         start_q <= cnt_load_s;
         done_q  <= (state_d == ST_DONE);
         if (accept_s) begin
            a_q      <= Ea;
            b_q      <= Eb;
            isdiv_q  <= is_div_op(Eop);
            signed_q <= is_signed_op(Eop);
         end
         if (divz_s) begin
            hi_q <= Ea;
            lo_q <= DIVZ_LO;
         end else if (capture_s) begin
            hi_q <= md_hi;
            lo_q <= md_lo;
         end
      end
   end

   // A flush or reset landing on the DONE cycle still suppresses the write.
   assign w_hi      = done_q & ~exc_flush & rst;
   assign w_lo      = done_q & ~exc_flush & rst;
   assign stall     = (state_q != ST_IDLE) & (is_md_op(Eop) | Erd_hilo) & ~exc_flush;
   assign md_start  = start_q;
   assign md_isdiv  = isdiv_q;
   assign md_signed = signed_q;
   assign md_a      = a_q;
   assign md_b      = b_q;
   assign hi_out    = hi_q;
   assign lo_out    = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Randomized scoreboard bench for md_sched against a cycle-timeline reference model.
module tb_md_sched;

   localparam int MUL_LAT = 4;
   localparam int DIV_LAT = 33;
   localparam int N_RAND  = 3000;
   localparam int N_DRAIN = 60;
   localparam int RST_CYC = 1500;

   typedef struct {
      int          c;
      logic [31:0] x;
      logic [31:0] y;
      logic        d;
      logic        s;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  Eop;
   logic [31:0] Ea, Eb, md_hi, md_lo;
   logic        Erd_hilo, exc_flush;
   logic        md_start, md_isdiv, md_signed, stall, w_hi, w_lo;
   logic [31:0] md_a, md_b, hi_out, lo_out;

   int   cyc      = 0;
   logic run      = 1'b0;
   logic exp_stall = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   ev_t  wq[$];
   ev_t  sq[$];

   md_sched #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .Eop(Eop), .Ea(Ea), .Eb(Eb), .Erd_hilo(Erd_hilo),
      .exc_flush(exc_flush), .md_hi(md_hi), .md_lo(md_lo), .md_start(md_start),
      .md_isdiv(md_isdiv), .md_signed(md_signed), .md_a(md_a), .md_b(md_b),
      .stall(stall), .hi_out(hi_out), .lo_out(lo_out), .w_hi(w_hi), .w_lo(w_lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Architectural result of the unit: {HI, LO}.
   function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [63:0] sa, sb, q, r;
      logic [63:0] p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      case (op)
         3'd1: begin p = sa * sb; return p; end
         3'd2: begin p = {32'd0, a} * {32'd0, b}; return p; end
         3'd3: begin q = sa / sb; r = sa % sb; return {r[31:0], q[31:0]}; end
         default: return {a % b, a / b};
      endcase
   endfunction

   // Stimulus and reference model: the unit is free from cycle free_c onward.
   initial begin
      int          free_c, res_c, lat;
      logic [63:0] res, cur_res;
      logic        opv, isd, sg;
      free_c = 0;
      res_c  = -1;
      cur_res = 64'd0;
      rst = 1'b0; Eop = 3'd0; Ea = 32'd0; Eb = 32'd0; Erd_hilo = 1'b0;
      exc_flush = 1'b0; md_hi = 32'd0; md_lo = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_start", {31'd0, md_start}, 32'd0);
      check("reset_stall", {31'd0, stall}, 32'd0);
      check("reset_w", {30'd0, w_hi, w_lo}, 32'd0);
      check("reset_kind", {30'd0, md_isdiv, md_signed}, 32'd0);
      check("reset_a", md_a, 32'd0);
      check("reset_b", md_b, 32'd0);
      check("reset_hi", hi_out, 32'd0);
      check("reset_lo", lo_out, 32'd0);
      rst = 1'b1;
      run = 1'b1;
      for (int k = 0; k < N_RAND + N_DRAIN; k++) begin
         @(posedge clk);
         #1;
         cyc++;
         rst = (cyc != RST_CYC) && (cyc != RST_CYC + 1);
         if (k < N_RAND) begin
            Eop       = 3'($urandom_range(0, 7));
            Ea        = $urandom;
            Eb        = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            Erd_hilo  = ($urandom_range(0, 3) == 0);
            exc_flush = ($urandom_range(0, 24) == 0);
         end else begin
            Eop = 3'd0; Erd_hilo = 1'b0; exc_flush = 1'b0;
         end
         opv = (Eop >= 3'd1) && (Eop <= 3'd4);
         exp_stall = (cyc < free_c) && (opv || Erd_hilo) && !exc_flush;
         if (cyc == res_c) begin
            md_hi = cur_res[63:32];
            md_lo = cur_res[31:0];
         end else begin
            md_hi = $urandom;
            md_lo = $urandom;
         end
         if (!rst) begin
            while (wq.size() > 0 && wq[$].c >= cyc) void'(wq.pop_back());
            while (sq.size() > 0 && sq[$].c > cyc) void'(sq.pop_back());
            res_c  = -1;
            free_c = cyc + 1;
         end else if (cyc < free_c) begin
            if (exc_flush) begin
               while (wq.size() > 0 && wq[$].c >= cyc) void'(wq.pop_back());
               res_c  = -1;
               free_c = cyc + 1;
            end
         end else if (opv && !exc_flush) begin
            isd = (Eop >= 3'd3);
            sg  = (Eop == 3'd1) || (Eop == 3'd3);
            if (isd && Eb == 32'd0) begin
               wq.push_back('{c: cyc + 1, x: Ea, y: 32'hFFFF_FFFF, d: 1'b1, s: sg});
               free_c = cyc + 2;
            end else begin
               lat = isd ? DIV_LAT : MUL_LAT;
               res = ref_res(Eop, Ea, Eb);
               cur_res = res;
               res_c = cyc + lat;
               sq.push_back('{c: cyc + 1, x: Ea, y: Eb, d: isd, s: sg});
               wq.push_back('{c: cyc + lat + 1, x: res[63:32], y: res[31:0], d: isd, s: sg});
               free_c = cyc + lat + 2;
            end
         end
      end
      @(negedge clk);
      run = 1'b0;
      check("pending_writes", 32'(wq.size()), 32'd0);
      check("pending_starts", 32'(sq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Monitor: compares DUT outputs with scoreboard entries each cycle.
   always @(negedge clk) begin
      if (run) begin
         ev_t e;
         check("stall", {31'd0, stall}, {31'd0, exp_stall});
         check("w_hi_eq_w_lo", {31'd0, w_hi}, {31'd0, w_lo});
         while (wq.size() > 0 && wq[0].c < cyc) begin
            e = wq.pop_front();
            check("missed_write_cycle", 32'(cyc), 32'(e.c));
         end
         while (sq.size() > 0 && sq[0].c < cyc) begin
            e = sq.pop_front();
            check("missed_start_cycle", 32'(cyc), 32'(e.c));
         end
         if (w_hi) begin
            if (wq.size() == 0) begin
               check("unexpected_write", 32'd1, 32'd0);
            end else begin
               e = wq.pop_front();
               check("write_cycle", 32'(cyc), 32'(e.c));
               check("hi_out", hi_out, e.x);
               check("lo_out", lo_out, e.y);
            end
         end
         if (md_start) begin
            if (sq.size() == 0) begin
               check("unexpected_start", 32'd1, 32'd0);
            end else begin
               e = sq.pop_front();
               check("start_cycle", 32'(cyc), 32'(e.c));
               check("md_a", md_a, e.x);
               check("md_b", md_b, e.y);
               check("md_kind", {30'd0, md_isdiv, md_signed}, {30'd0, e.d, e.s});
            end
         end
         if (cyc == RST_CYC + 2) begin
            check("midrun_reset_hi", hi_out, 32'd0);
            check("midrun_reset_lo", lo_out, 32'd0);
            check("midrun_reset_a", md_a, 32'd0);
         end
      end
   end

endmodule
